// File: rtl/seg7_scan_driver.sv
// Purpose: time-multiplexed 8-digit seven-segment driver with per-digit blink and decimal point.
// Latency: AN/SEGMENT follow the digit index by 1 cycle; inputs become visible only at the next frame wrap.
// Backpressure: none; free-running display scanner, inputs are sampled once per frame.
module seg7_scan_driver #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Disp_num,
    input  logic [7:0]  LE_out,
    input  logic [7:0]  point_out,
    output logic [7:0]  AN,
    output logic [7:0]  SEGMENT,
    output logic        frame_done
);

    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [SCAN_W-1:0]  scan_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic [2:0]         digit_idx;
    logic               blink_phase;
    logic [31:0]        shadow_num;
    logic [7:0]         shadow_le;
    logic [7:0]         shadow_pt;

    logic               scan_term;
    logic               frame_wrap;
    logic [3:0]         cur_nibble;
    logic               cur_blank;

    assign scan_term  = (scan_cnt == SCAN_LAST);
    assign frame_wrap = scan_term && (digit_idx == 3'd7);
    assign cur_nibble = shadow_num[{digit_idx, 2'b00} +: 4];
    assign cur_blank  = shadow_le[digit_idx] && blink_phase;

    // Active-low glyph for one hex nibble, bit0 = segment a.
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    // Dwell counter: each digit is held for SCAN_DIV cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
        end else if (scan_term) begin
            scan_cnt <= '0;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Digit index advances at the end of each dwell and wraps 7 -> 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_idx <= 3'd0;
        end else if (scan_term) begin
            digit_idx <= digit_idx + 3'd1;
        end
    end

    // Inputs are captured only at the frame wrap so a frame never shows a torn value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_num <= '0;
            shadow_le  <= '0;
            shadow_pt  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_wrap;
            if (frame_wrap) begin
                shadow_num <= Disp_num;
                shadow_le  <= LE_out;
                shadow_pt  <= point_out;
            end
        end
    end

    // Blink half-period timer; phase 0 is the visible half.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt   <= blink_cnt + 1'b1;
        end
    end

    // Registered output stage: recomputed every cycle so blanking can change mid-dwell.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            AN      <= 8'hFF;
            SEGMENT <= 8'hFF;
        end else if (cur_blank) begin
            AN      <= 8'hFF;
            SEGMENT <= 8'hFF;
        end else begin
            AN      <= ~(8'd1 << digit_idx);
            SEGMENT <= {~shadow_pt[digit_idx], hex_glyph(cur_nibble)};
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Purpose: self-checking bench for seg7_scan_driver with a per-cycle expected-output scoreboard.
// Latency: expected entry for an edge is pushed before the edge and compared on the following falling edge.
// Backpressure: none; the bench steps the clock one cycle at a time.
module tb_seg7_scan_driver;

    localparam int SD = 4;
    localparam int BD = 64;
    localparam int FRAME = 8 * SD;

    typedef struct {
        logic [7:0] an;
        logic [7:0] seg;
        logic       fd;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] Disp_num;
    logic [7:0]  LE_out;
    logic [7:0]  point_out;
    logic [7:0]  AN;
    logic [7:0]  SEGMENT;
    logic        frame_done;

    exp_t        sb[$];
    logic [6:0]  glyph_tab [16];

    // Reference state: edges since reset release and the modelled shadow registers.
    int          n;
    logic [31:0] m_num;
    logic [7:0]  m_le;
    logic [7:0]  m_pt;

    int errors;
    int checks;

    seg7_scan_driver #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clk        (clk),
        .rst        (rst),
        .Disp_num   (Disp_num),
        .LE_out     (LE_out),
        .point_out  (point_out),
        .AN         (AN),
        .SEGMENT    (SEGMENT),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs after the next edge, from the state reached after n edges.
    function automatic exp_t model_out();
        exp_t e;
        int d;
        logic ph;
        logic [3:0] nib;
        d   = (n / SD) % 8;
        ph  = ((n / BD) % 2) == 1;
        nib = m_num[d*4 +: 4];
        if (m_le[d] && ph) begin
            e.an  = 8'hFF;
            e.seg = 8'hFF;
        end else begin
            e.an  = ~(8'd1 << d);
            e.seg = {~m_pt[d], glyph_tab[nib]};
        end
        e.fd = ((n + 1) % FRAME) == 0;
        return e;
    endfunction

    // Push the expectation for the coming edge, clock once, then move to the sampling point.
    task automatic advance();
        sb.push_back(model_out());
        @(posedge clk);
        if ((n % FRAME) == FRAME - 1) begin
            m_num = Disp_num;
            m_le  = LE_out;
            m_pt  = point_out;
        end
        n++;
        @(negedge clk);
    endtask

    task automatic model_reset();
        n     = 0;
        m_num = '0;
        m_le  = '0;
        m_pt  = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (AN !== 8'hFF) begin
            errors++;
            $display("FAIL reset_an got=%h want=ff", AN);
        end
        checks++;
        if (SEGMENT !== 8'hFF) begin
            errors++;
            $display("FAIL reset_seg got=%h want=ff", SEGMENT);
        end
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_fd got=%b want=0", frame_done);
        end
    endtask

    task automatic test_first_frame();
        exp_t e;
        Disp_num  = 32'h1234_5678;
        LE_out    = 8'h00;
        point_out = 8'h00;
        model_reset();
        rst = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            advance();
            e = sb.pop_front();
            checks++;
            if (AN !== e.an || SEGMENT !== e.seg || frame_done !== e.fd) begin
                errors++;
                $display("FAIL first_frame cyc=%0d AN=%h want=%h SEG=%h want=%h fd=%b want=%b",
                         n, AN, e.an, SEGMENT, e.seg, frame_done, e.fd);
            end
        end
    endtask

    task automatic test_frame_period();
        exp_t e;
        int last_fd;
        int run_len;
        int changes;
        logic [7:0] prev_an;
        last_fd = -1;
        run_len = 0;
        changes = 0;
        prev_an = AN;
        for (int i = 0; i < 3 * FRAME; i++) begin
            advance();
            e = sb.pop_front();
            checks++;
            if (AN !== e.an || SEGMENT !== e.seg || frame_done !== e.fd) begin
                errors++;
                $display("FAIL frame_period_out cyc=%0d AN=%h want=%h SEG=%h want=%h fd=%b want=%b",
                         n, AN, e.an, SEGMENT, e.seg, frame_done, e.fd);
            end
            if (frame_done === 1'b1) begin
                if (last_fd >= 0) begin
                    checks++;
                    if (n - last_fd != FRAME) begin
                        errors++;
                        $display("FAIL frame_gap got=%0d want=%0d", n - last_fd, FRAME);
                    end
                end
                last_fd = n;
            end
            if (AN !== prev_an) begin
                if (changes > 0) begin
                    checks++;
                    if (run_len != SD) begin
                        errors++;
                        $display("FAIL an_hold got=%0d want=%0d", run_len, SD);
                    end
                end
                changes++;
                run_len = 1;
                prev_an = AN;
            end else begin
                run_len++;
            end
        end
        checks++;
        if (last_fd < 0) begin
            errors++;
            $display("FAIL frame_done_seen got=none want=pulse");
        end
    endtask

    task automatic test_change_mid_frame();
        exp_t e;
        int guard;
        guard = 0;
        while ((n % FRAME) != 12 && guard < FRAME) begin
            advance();
            e = sb.pop_front();
            checks++;
            if (AN !== e.an || SEGMENT !== e.seg || frame_done !== e.fd) begin
                errors++;
                $display("FAIL change_pre cyc=%0d AN=%h want=%h SEG=%h want=%h", n, AN, e.an, SEGMENT, e.seg);
            end
            guard++;
        end
        Disp_num = 32'hFEDC_BA98;
        for (int i = 0; i < 2 * FRAME; i++) begin
            advance();
            e = sb.pop_front();
            checks++;
            if (AN !== e.an || SEGMENT !== e.seg || frame_done !== e.fd) begin
                errors++;
                $display("FAIL change_mid cyc=%0d AN=%h want=%h SEG=%h want=%h fd=%b want=%b",
                         n, AN, e.an, SEGMENT, e.seg, frame_done, e.fd);
            end
        end
    endtask

    task automatic test_points();
        exp_t e;
        Disp_num  = 32'h0000_0000;
        point_out = 8'h01;
        for (int i = 0; i < 2 * FRAME; i++) begin
            advance();
            e = sb.pop_front();
            checks++;
            if (AN !== e.an || SEGMENT !== e.seg || frame_done !== e.fd) begin
                errors++;
                $display("FAIL points cyc=%0d AN=%h want=%h SEG=%h want=%h fd=%b want=%b",
                         n, AN, e.an, SEGMENT, e.seg, frame_done, e.fd);
            end
        end
    endtask

    task automatic test_blink();
        exp_t e;
        int dark;
        dark      = 0;
        Disp_num  = 32'h1234_5678;
        point_out = 8'h00;
        LE_out    = 8'h04;
        for (int i = 0; i < 10 * FRAME; i++) begin
            advance();
            e = sb.pop_front();
            checks++;
            if (AN !== e.an || SEGMENT !== e.seg || frame_done !== e.fd) begin
                errors++;
                $display("FAIL blink cyc=%0d AN=%h want=%h SEG=%h want=%h fd=%b want=%b",
                         n, AN, e.an, SEGMENT, e.seg, frame_done, e.fd);
            end
            if (AN === 8'hFF) dark++;
        end
        checks++;
        if (dark == 0) begin
            errors++;
            $display("FAIL blink_dark_seen got=%0d want=nonzero", dark);
        end
        LE_out = 8'h00;
    endtask

    task automatic test_async_reset();
        exp_t e;
        int guard;
        guard = 0;
        Disp_num = 32'hFEDC_BA98;
        while (!(((n / SD) % 8) == 5 && (n % SD) == 1) && guard < 3 * FRAME) begin
            advance();
            e = sb.pop_front();
            checks++;
            if (AN !== e.an || SEGMENT !== e.seg || frame_done !== e.fd) begin
                errors++;
                $display("FAIL areset_pre cyc=%0d AN=%h want=%h SEG=%h want=%h", n, AN, e.an, SEGMENT, e.seg);
            end
            guard++;
        end
        checks++;
        if (AN !== 8'hDF) begin
            errors++;
            $display("FAIL areset_digit5 got=%h want=df", AN);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (AN !== 8'hFF) begin
            errors++;
            $display("FAIL areset_an got=%h want=ff", AN);
        end
        checks++;
        if (SEGMENT !== 8'hFF) begin
            errors++;
            $display("FAIL areset_seg got=%h want=ff", SEGMENT);
        end
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL areset_fd got=%b want=0", frame_done);
        end
        @(negedge clk);
        model_reset();
        rst = 1'b0;
        for (int i = 0; i < FRAME + 12; i++) begin
            advance();
            e = sb.pop_front();
            checks++;
            if (AN !== e.an || SEGMENT !== e.seg || frame_done !== e.fd) begin
                errors++;
                $display("FAIL areset_post cyc=%0d AN=%h want=%h SEG=%h want=%h fd=%b want=%b",
                         n, AN, e.an, SEGMENT, e.seg, frame_done, e.fd);
            end
        end
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        Disp_num  = 32'h1234_5678;
        LE_out    = 8'h00;
        point_out = 8'h00;
        glyph_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        model_reset();

        test_reset();
        test_first_frame();
        test_frame_period();
        test_change_mid_frame();
        test_points();
        test_blink();
        test_async_reset();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left got=%0d want=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
